// File: rtl/noise_scale_offset.sv
// Pipelined fixed-point scale-and-offset: m_data = offset + ((s_data * scale) >> FRAC_SHIFT),
// with optional saturation, valid/ready backpressure and frame-aligned coefficient swap.
module noise_scale_offset #(
  parameter int DATA_W     = 32,
  parameter int SCALE_W    = 32,
  parameter int FRAC_SHIFT = 24,
  parameter int SIGNED     = 0,
  parameter int SAT_EN     = 0
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  input  logic               cfg_wr,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [DATA_W-1:0]  cfg_offset,
  output logic               cfg_pending,
  input  logic               sat_clr,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic               m_sat,
  output logic [15:0]        sat_count
);

  localparam int PROD_W = DATA_W + SCALE_W;
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] U_MAX = {DATA_W{1'b1}};

  function automatic logic [PROD_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                input logic [SCALE_W-1:0] b);
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;
    if (SIGNED != 0) begin
      ea = {{SCALE_W{a[DATA_W-1]}}, a};
      eb = {{DATA_W{b[SCALE_W-1]}}, b};
    end else begin
      ea = {{SCALE_W{1'b0}}, a};
      eb = {{DATA_W{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  function automatic logic [PROD_W-1:0] shift_prod(input logic [PROD_W-1:0] p);
    if (SIGNED != 0) begin
      return PROD_W'($signed(p) >>> FRAC_SHIFT);
    end else begin
      return p >> FRAC_SHIFT;
    end
  endfunction

  // Returns {clamped, value}: narrows the shifted product to DATA_W.
  function automatic logic [DATA_W:0] clamp_term(input logic [PROD_W-1:0] v);
    logic [SCALE_W:0]   hi_s;
    logic [SCALE_W-1:0] hi_u;
    hi_s = v[PROD_W-1:DATA_W-1];
    hi_u = v[PROD_W-1:DATA_W];
    if (SAT_EN == 0) begin
      return {1'b0, v[DATA_W-1:0]};
    end else if (SIGNED != 0) begin
      if ((&hi_s) || !(|hi_s)) begin
        return {1'b0, v[DATA_W-1:0]};
      end else begin
        return {1'b1, (v[PROD_W-1] ? S_MIN : S_MAX)};
      end
    end else if (|hi_u) begin
      return {1'b1, U_MAX};
    end else begin
      return {1'b0, v[DATA_W-1:0]};
    end
  endfunction

  // Returns {clamped, value}: DATA_W+1 bit sum, clamped or wrapped to DATA_W.
  function automatic logic [DATA_W:0] add_sat(input logic [DATA_W-1:0] t,
                                              input logic [DATA_W-1:0] o);
    logic [DATA_W:0] sum;
    if (SIGNED != 0) begin
      sum = {t[DATA_W-1], t} + {o[DATA_W-1], o};
    end else begin
      sum = {1'b0, t} + {1'b0, o};
    end
    if (SAT_EN == 0) begin
      return {1'b0, sum[DATA_W-1:0]};
    end else if (SIGNED != 0) begin
      if (sum[DATA_W] != sum[DATA_W-1]) begin
        return {1'b1, (sum[DATA_W] ? S_MIN : S_MAX)};
      end else begin
        return {1'b0, sum[DATA_W-1:0]};
      end
    end else if (sum[DATA_W]) begin
      return {1'b1, U_MAX};
    end else begin
      return {1'b0, sum[DATA_W-1:0]};
    end
  endfunction

  logic               pipe_en_s, accept_s, apply_s, sum_sat_s;
  logic [SCALE_W-1:0] beat_scale_s;
  logic [DATA_W-1:0]  beat_offset_s;

  logic [SCALE_W-1:0] pend_scale_q, pend_scale_d, act_scale_q, act_scale_d;
  logic [DATA_W-1:0]  pend_offset_q, pend_offset_d, act_offset_q, act_offset_d;
  logic               cfg_pending_q, cfg_pending_d, in_frame_q, in_frame_d;
  logic [15:0]        sat_count_q, sat_count_d;

  logic               s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [DATA_W-1:0]  s1_data_q, s1_data_d, s1_offset_q, s1_offset_d;
  logic [SCALE_W-1:0] s1_scale_q, s1_scale_d;
  logic               s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [PROD_W-1:0]  s2_prod_q, s2_prod_d;
  logic [DATA_W-1:0]  s2_offset_q, s2_offset_d;
  logic               s3_valid_q, s3_valid_d, s3_last_q, s3_last_d, s3_sat_q, s3_sat_d;
  logic [DATA_W-1:0]  s3_term_q, s3_term_d, s3_offset_q, s3_offset_d;
  logic               m_valid_q, m_valid_d, m_last_q, m_last_d, m_sat_q, m_sat_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;

  // s_ready is deliberately combinational from m_ready so the whole pipe stalls as one.
  assign pipe_en_s = !m_valid_q || m_ready;
  assign accept_s  = s_valid && pipe_en_s;
  assign apply_s   = accept_s && !in_frame_q && cfg_pending_q;

  // Coefficient bookkeeping: pending/active sets, frame tracking, saturation counter.
  always_comb begin
    pend_scale_d  = pend_scale_q;
    pend_offset_d = pend_offset_q;
    cfg_pending_d = cfg_pending_q;
    act_scale_d   = act_scale_q;
    act_offset_d  = act_offset_q;
    in_frame_d    = in_frame_q;
    sat_count_d   = sat_count_q;
    beat_scale_s  = act_scale_q;
    beat_offset_s = act_offset_q;
    if (cfg_wr) begin
      pend_scale_d  = cfg_scale;
      pend_offset_d = cfg_offset;
      cfg_pending_d = 1'b1;
    end else if (apply_s) begin
      cfg_pending_d = 1'b0;
    end else begin
      cfg_pending_d = cfg_pending_q;
    end
    if (apply_s) begin
      act_scale_d   = pend_scale_q;
      act_offset_d  = pend_offset_q;
      beat_scale_s  = pend_scale_q;
      beat_offset_s = pend_offset_q;
    end else begin
      act_scale_d   = act_scale_q;
      act_offset_d  = act_offset_q;
    end
    if (accept_s) begin
      in_frame_d = !s_last;
    end else begin
      in_frame_d = in_frame_q;
    end
    if (sat_clr) begin
      sat_count_d = 16'h0000;
    end else if (m_valid_q && m_ready && m_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'h0001;
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // Datapath next values; the registers only load them while pipe_en_s is high.
  always_comb begin
    s1_valid_d  = s_valid;
    s1_data_d   = s_data;
    s1_last_d   = s_last;
    s1_scale_d  = beat_scale_s;
    s1_offset_d = beat_offset_s;
    s2_valid_d  = s1_valid_q;
    s2_prod_d   = mul_ext(s1_data_q, s1_scale_q);
    s2_last_d   = s1_last_q;
    s2_offset_d = s1_offset_q;
    s3_valid_d  = s2_valid_q;
    {s3_sat_d, s3_term_d} = clamp_term(shift_prod(s2_prod_q));
    s3_last_d   = s2_last_q;
    s3_offset_d = s2_offset_q;
    {sum_sat_s, m_data_d} = add_sat(s3_term_q, s3_offset_q);
    m_sat_d     = s3_sat_q | sum_sat_s;
    m_valid_d   = s3_valid_q;
    m_last_d    = s3_last_q;
  end

  // State registers; reset discards in-flight beats and any pending coefficients.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend_scale_q  <= {SCALE_W{1'b0}};
      pend_offset_q <= {DATA_W{1'b0}};
      cfg_pending_q <= 1'b0;
      act_scale_q   <= {SCALE_W{1'b0}};
      act_offset_q  <= {DATA_W{1'b0}};
      in_frame_q    <= 1'b0;
      sat_count_q   <= 16'h0000;
      s1_valid_q    <= 1'b0;
      s1_data_q     <= {DATA_W{1'b0}};
      s1_last_q     <= 1'b0;
      s1_scale_q    <= {SCALE_W{1'b0}};
      s1_offset_q   <= {DATA_W{1'b0}};
      s2_valid_q    <= 1'b0;
      s2_prod_q     <= {PROD_W{1'b0}};
      s2_last_q     <= 1'b0;
      s2_offset_q   <= {DATA_W{1'b0}};
      s3_valid_q    <= 1'b0;
      s3_term_q     <= {DATA_W{1'b0}};
      s3_last_q     <= 1'b0;
      s3_sat_q      <= 1'b0;
      s3_offset_q   <= {DATA_W{1'b0}};
      m_valid_q     <= 1'b0;
      m_data_q      <= {DATA_W{1'b0}};
      m_last_q      <= 1'b0;
      m_sat_q       <= 1'b0;
    end else begin
      pend_scale_q  <= pend_scale_d;
      pend_offset_q <= pend_offset_d;
      cfg_pending_q <= cfg_pending_d;
      act_scale_q   <= act_scale_d;
      act_offset_q  <= act_offset_d;
      in_frame_q    <= in_frame_d;
      sat_count_q   <= sat_count_d;
      if (pipe_en_s) begin
        s1_valid_q  <= s1_valid_d;
        s1_data_q   <= s1_data_d;
        s1_last_q   <= s1_last_d;
        s1_scale_q  <= s1_scale_d;
        s1_offset_q <= s1_offset_d;
        s2_valid_q  <= s2_valid_d;
        s2_prod_q   <= s2_prod_d;
        s2_last_q   <= s2_last_d;
        s2_offset_q <= s2_offset_d;
        s3_valid_q  <= s3_valid_d;
        s3_term_q   <= s3_term_d;
        s3_last_q   <= s3_last_d;
        s3_sat_q    <= s3_sat_d;
        s3_offset_q <= s3_offset_d;
        m_valid_q   <= m_valid_d;
        m_data_q    <= m_data_d;
        m_last_q    <= m_last_d;
        m_sat_q     <= m_sat_d;
      end
    end
  end

  assign s_ready     = pipe_en_s;
  assign cfg_pending = cfg_pending_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign m_sat       = m_sat_q;
  assign sat_count   = sat_count_q;

endmodule
